lock_key_loader: RTL and testbench

- Sequencer that configures the key inputs of a locked combinational benchmark netlist, for example the mux/XOR-locked c499 SEC core with 12 key bits: p1..p4 and X_1..X_8.
- Accepts a key serially over a valid/ready handshake into a shadow register and optionally checks frame parity.
- Commits the key to the locked core's key pins, waits a settle window, then flags the key active.
- Counts failed loads and enters permanent lockout after a configured number of failures.

---
 rtl/lock_key_loader.sv | 170 +++++++++++++++++
 tb/tb_lock_key_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key loader that drives the key pins of a locked combinational core.
// Optional frame parity check is enabled with `define KEY_PARITY_EN.
module lock_key_loader #(
  parameter int unsigned KEY_W      = 12,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAX_FAIL   = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             abort_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] key_out_o,
  output logic             key_active_o,
  output logic             busy_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             lockout_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StShift   = 3'd1;
`ifdef KEY_PARITY_EN
  localparam logic [2:0] StPar     = 3'd2;
`endif
  localparam logic [2:0] StCheck   = 3'd3;
  localparam logic [2:0] StApply   = 3'd4;
  localparam logic [2:0] StLockout = 3'd5;

  localparam logic [CNT_W-1:0] LastBit    = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MaxFail    = CNT_W'(MAX_FAIL);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_active_q, key_active_d;
  logic             accept;
  logic             pass;
  logic [CNT_W-1:0] fail_inc;
`ifdef KEY_PARITY_EN
  logic             par_q, par_d;

  assign key_ready_o = (state_q == StShift) || (state_q == StPar);
  // Even parity: key bits plus parity bit must XOR to zero.
  assign pass        = ~(^{shadow_q, par_q});
`else
  assign key_ready_o = (state_q == StShift);
  assign pass        = 1'b1;
`endif

  assign accept   = key_ready_o && key_valid_i;
  assign fail_inc = (fail_cnt_q == MaxFail) ? fail_cnt_q : fail_cnt_q + CntOne;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    bit_cnt_d    = bit_cnt_q;
    settle_d     = settle_q;
    fail_cnt_d   = fail_cnt_q;
    key_out_d    = key_out_q;
    key_active_d = key_active_q;
`ifdef KEY_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (load_start_i) begin
          state_d      = StShift;
          shadow_d     = '0;
          bit_cnt_d    = '0;
          key_active_d = 1'b0;
        end
      end
      StShift: begin
        // Abort beats a simultaneous beat; the bit is dropped.
        if (abort_i) begin
          state_d = StIdle;
        end else if (accept) begin
          shadow_d  = {shadow_q[KEY_W-2:0], key_bit_i};
          bit_cnt_d = bit_cnt_q + CntOne;
          if (bit_cnt_q == LastBit) begin
`ifdef KEY_PARITY_EN
            state_d = StPar;
`else
            state_d = StCheck;
`endif
          end
        end
      end
`ifdef KEY_PARITY_EN
      StPar: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (accept) begin
          par_d   = key_bit_i;
          state_d = StCheck;
        end
      end
`endif
      StCheck: begin
        if (pass) begin
          key_out_d = shadow_q;
          settle_d  = '0;
          state_d   = StApply;
        end else begin
          fail_cnt_d = fail_inc;
          if (fail_inc == MaxFail) begin
            state_d   = StLockout;
            key_out_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StApply: begin
        if (settle_q == SettleLast) begin
          state_d      = StIdle;
          key_active_d = 1'b1;
          fail_cnt_d   = '0;
        end else begin
          settle_d = settle_q + CntOne;
        end
      end
      StLockout: state_d = StLockout;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      bit_cnt_q    <= '0;
      settle_q     <= '0;
      fail_cnt_q   <= '0;
      key_out_q    <= '0;
      key_active_q <= 1'b0;
`ifdef KEY_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_q     <= settle_d;
      fail_cnt_q   <= fail_cnt_d;
      key_out_q    <= key_out_d;
      key_active_q <= key_active_d;
`ifdef KEY_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign key_out_o    = key_out_q;
  assign key_active_o = key_active_q;
  assign busy_o       = (state_q != StIdle) && (state_q != StLockout);
  assign fail_o       = (state_q == StCheck) && !pass;
  assign fail_cnt_o   = fail_cnt_q;
  assign lockout_o    = (state_q == StLockout);

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: frame-level reference model compared every cycle,
// directed scenarios plus randomized loads. Honours `define KEY_PARITY_EN.
module tb_lock_key_loader;

  localparam int KEY_W    = 12;
  localparam int SETTLE   = 4;
  localparam int MAX_FAIL = 3;
  localparam int CNT_W    = 4;
`ifdef KEY_PARITY_EN
  localparam int FRAME  = KEY_W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME  = KEY_W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, load_start, abort, key_bit, key_valid;
  logic             key_ready, key_active, busy, fail, lockout;
  logic [KEY_W-1:0] key_out;
  logic [CNT_W-1:0] fail_cnt;

  lock_key_loader #(
    .KEY_W(KEY_W), .SETTLE_CYC(SETTLE), .MAX_FAIL(MAX_FAIL), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(load_start), .abort_i(abort),
    .key_bit_i(key_bit), .key_valid_i(key_valid), .key_ready_o(key_ready),
    .key_out_o(key_out), .key_active_o(key_active), .busy_o(busy), .fail_o(fail),
    .fail_cnt_o(fail_cnt), .lockout_o(lockout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: a load is a queue of received bits, then a check
  // cycle, then a settle countdown.
  bit               m_loading, m_check, m_lock, m_act;
  int               m_apply, m_fail_cnt;
  logic [KEY_W-1:0] m_key;
  bit               m_q[$];

  function automatic logic [KEY_W-1:0] frame_key();
    logic [KEY_W-1:0] k = '0;
    for (int i = 0; i < KEY_W; i++) k = {k[KEY_W-2:0], m_q[i]};
    return k;
  endfunction

  function automatic bit frame_good();
    bit x = 1'b0;
    if (!PAR_EN) return 1'b1;
    foreach (m_q[i]) x ^= m_q[i];
    return !x;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_loading = 0; m_check = 0; m_lock = 0; m_act = 0;
      m_apply = 0; m_fail_cnt = 0; m_key = '0; m_q.delete();
    end else if (m_lock) begin
      // inputs ignored until reset
    end else if (m_loading) begin
      if (abort) begin
        m_loading = 0; m_q.delete();
      end else if (key_valid) begin
        m_q.push_back(key_bit);
        if (m_q.size() == FRAME) begin
          m_loading = 0; m_check = 1;
        end
      end
    end else if (m_check) begin
      m_check = 0;
      if (frame_good()) begin
        m_key = frame_key(); m_apply = SETTLE;
      end else begin
        if (m_fail_cnt < MAX_FAIL) m_fail_cnt++;
        if (m_fail_cnt == MAX_FAIL) begin
          m_lock = 1; m_key = '0;
        end
      end
    end else if (m_apply > 0) begin
      m_apply--;
      if (m_apply == 0) begin
        m_act = 1; m_fail_cnt = 0;
      end
    end else if (load_start) begin
      m_loading = 1; m_act = 0; m_q.delete();
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("key_ready", key_ready, m_loading);
    chk("busy", busy, m_loading || m_check || (m_apply > 0));
    chk("fail", fail, m_check && !frame_good());
    chk("fail_cnt", fail_cnt, m_fail_cnt);
    chk("lockout", lockout, m_lock);
    chk("key_out", key_out, m_key);
    chk("key_active", key_active, m_act);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  function automatic logic [KEY_W:0] make_frame(input logic [KEY_W-1:0] k, input bit bad);
    if (PAR_EN) return {k, (^k) ^ bad};
    return {1'b0, k};
  endfunction

  // Sends FRAME bits MSB first with random gaps; abort_at >= 0 aborts on that beat.
  task automatic stream(input logic [KEY_W:0] fr, input int max_gap, input int abort_at,
                        input bit noise);
    for (int i = 0; i < FRAME; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        key_valid = 1'b0; key_bit = 1'($urandom);
        load_start = noise && ($urandom_range(2, 0) == 0);
        tick();
      end
      key_valid = 1'b1; key_bit = fr[FRAME-1-i];
      load_start = noise && ($urandom_range(2, 0) == 0);
      if (i == abort_at) begin
        abort = 1'b1; tick(); abort = 1'b0; key_valid = 1'b0; load_start = 1'b0;
        return;
      end
      tick();
    end
    key_valid = 1'b0; load_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick(); n++;
    end
    chk("idle_timeout", n < 100, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [KEY_W-1:0] k;
    rst_n = 1'b0; load_start = 0; abort = 0; key_bit = 0; key_valid = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_key_out", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", key_ready, 0);

    // Good load and commit latency.
    pulse_start();
    chk("t1_ready", key_ready, 1);
    stream(make_frame(12'hA5C, 0), 0, -1, 0);
    n = 0;
    while (!key_active && n < 20) begin
      tick(); n++;
    end
    chk("t1_latency", n, SETTLE + 1);
    chk("t1_key_out", key_out, 12'hA5C);
    chk("t1_busy", busy, 0);
    chk("t1_fail_cnt", fail_cnt, 0);

`ifdef KEY_PARITY_EN
    // Bad parity, then lockout after three consecutive failures.
    pulse_start();
    stream(make_frame(12'hA5C, 1), 0, -1, 0);
    chk("t2_fail_pulse", fail, 1);
    wait_idle();
    chk("t2_fail_cnt", fail_cnt, 1);
    chk("t2_key_out", key_out, 12'hA5C);
    chk("t2_key_active", key_active, 0);
    repeat (2) begin
      pulse_start();
      stream(make_frame(12'h123, 1), 1, -1, 0);
      wait_idle();
    end
    chk("t3_lockout", lockout, 1);
    chk("t3_key_out", key_out, 0);
    chk("t3_fail_cnt", fail_cnt, MAX_FAIL);
    pulse_start();
    tick();
    chk("t3_ignored_ready", key_ready, 0);
    chk("t3_ignored_busy", busy, 0);
`endif
    do_reset();
    chk("reset_lockout", lockout, 0);
    chk("reset_key_out", key_out, 0);
    chk("reset_fail_cnt", fail_cnt, 0);

    // Stalled stream aborted mid-frame, abort in idle, then a stalled good load.
    pulse_start();
    stream(make_frame(12'h777, 0), 3, 5, 0);
    tick();
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_fail_cnt", fail_cnt, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_idle_abort", busy, 0);
    pulse_start();
    stream(make_frame(12'h3C1, 0), 3, -1, 1);
    wait_idle();
    chk("t4_key_out", key_out, 12'h3C1);
    chk("t4_key_active", key_active, 1);

    // Reset during APPLY with the settle counter at 2.
    pulse_start();
    stream(make_frame(12'h5A3, 0), 0, -1, 0);
    repeat (3) tick();
    chk("t5_in_apply", busy, 1);
    do_reset();
    chk("t5_key_out", key_out, 0);
    chk("t5_key_active", key_active, 0);
    chk("t5_busy", busy, 0);

    // Randomized loads.
    for (int it = 0; it < 60; it++) begin
      if (lockout) do_reset();
      abort = 1'($urandom); tick(); abort = 1'b0;
      k = KEY_W'($urandom);
      pulse_start();
      stream(make_frame(k, PAR_EN && ($urandom_range(2, 0) == 0)), 3,
             ($urandom_range(4, 0) == 0) ? int'($urandom_range(FRAME - 1, 0)) : -1, 1);
      if ($urandom_range(7, 0) == 0) begin
        repeat ($urandom_range(6, 0)) tick();
        do_reset();
      end
      wait_idle();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
